// File: rtl/frame_update_scheduler.sv
// Grants the shared snake/food memory to game logic during vertical blanking every N frames.
// upd_req/mem_sel rise one clock after frame_end; upd_req is held until upd_done arrives.
module frame_update_scheduler #(
  parameter int H_LAST = 1439,
  parameter int V_LAST = 899,
  parameter int DIV0   = 8,
  parameter int DIV1   = 6,
  parameter int DIV2   = 4,
  parameter int DIV3   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] curr_x,
  input  logic [10:0] curr_y,
  input  logic        pause,
  input  logic [1:0]  speed_sel,
  input  logic        upd_done,
  output logic        upd_req,
  output logic        mem_sel,
  output logic [15:0] tick_count,
  output logic        overrun
);

  typedef enum logic [1:0] {RUN, GRANT, LATE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  divisor_q, divisor_d;
  logic        div_init_q, div_init_d;
  logic [10:0] curr_y_q, curr_y_d;
  logic        pos_last_q, pos_last_d;
  logic        upd_req_q, upd_req_d;
  logic        mem_sel_q, mem_sel_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic        overrun_q, overrun_d;

  logic pos_last;
  logic frame_end;
  logic frame_start;

  function automatic logic [7:0] sel_div(input logic [1:0] s);
    case (s)
      2'd0:    return 8'(DIV0);
      2'd1:    return 8'(DIV1);
      2'd2:    return 8'(DIV2);
      default: return 8'(DIV3);
    endcase
  endfunction

  assign pos_last    = (curr_x == 11'(H_LAST)) && (curr_y == 11'(V_LAST));
  assign frame_end   = pos_last && !pos_last_q;
  assign frame_start = (curr_y_q == 11'(V_LAST)) && (curr_y != 11'(V_LAST));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    divisor_d    = divisor_q;
    div_init_d   = 1'b1;
    curr_y_d     = curr_y;
    pos_last_d   = pos_last;
    upd_req_d    = upd_req_q;
    mem_sel_d    = mem_sel_q;
    tick_count_d = tick_count_q;
    overrun_d    = overrun_q;

    // First clock after reset release picks up the requested speed.
    if (!div_init_q) begin
      divisor_d = sel_div(speed_sel);
    end

    case (state_q)
      RUN: begin
        upd_req_d = 1'b0;
        mem_sel_d = 1'b0;
        if (frame_end && !pause) begin
          if (div_cnt_q == divisor_q - 8'd1) begin
            div_cnt_d = 8'd0;
            upd_req_d = 1'b1;
            mem_sel_d = 1'b1;
            divisor_d = sel_div(speed_sel);
            state_d   = GRANT;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
      end
      GRANT: begin
        if (upd_done) begin
          upd_req_d    = 1'b0;
          mem_sel_d    = 1'b0;
          tick_count_d = tick_count_q + 16'd1;
          state_d      = RUN;
        end else if (frame_start) begin
          // Visible area is starting: renderer takes the memory back.
          overrun_d = 1'b1;
          mem_sel_d = 1'b0;
          state_d   = LATE;
        end
      end
      LATE: begin
        if (upd_done) begin
          upd_req_d    = 1'b0;
          tick_count_d = tick_count_q + 16'd1;
          state_d      = RUN;
        end
      end
      default: begin
        upd_req_d = 1'b0;
        mem_sel_d = 1'b0;
        state_d   = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      div_cnt_q    <= 8'd0;
      divisor_q    <= 8'(DIV0);
      div_init_q   <= 1'b0;
      curr_y_q     <= 11'd0;
      pos_last_q   <= 1'b0;
      upd_req_q    <= 1'b0;
      mem_sel_q    <= 1'b0;
      tick_count_q <= 16'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      divisor_q    <= divisor_d;
      div_init_q   <= div_init_d;
      curr_y_q     <= curr_y_d;
      pos_last_q   <= pos_last_d;
      upd_req_q    <= upd_req_d;
      mem_sel_q    <= mem_sel_d;
      tick_count_q <= tick_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign upd_req    = upd_req_q;
  assign mem_sel    = mem_sel_q;
  assign tick_count = tick_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: frame sequencing, handshake, overrun, pause, reset.
module tb_frame_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] curr_x;
  logic [10:0] curr_y;
  logic        pause;
  logic [1:0]  speed_sel;
  logic        upd_done;
  logic        upd_req;
  logic        mem_sel;
  logic [15:0] tick_count;
  logic        overrun;

  int vectors = 0;
  int errs    = 0;

  frame_update_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .curr_x    (curr_x),
    .curr_y    (curr_y),
    .pause     (pause),
    .speed_sel (speed_sel),
    .upd_done  (upd_done),
    .upd_req   (upd_req),
    .mem_sel   (mem_sel),
    .tick_count(tick_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    curr_x = 11'(x);
    curr_y = 11'(y);
    step();
  endtask

  // Walks down the frame and lands on the last visible pixel; returns just after frame_end is registered.
  task automatic reach_end();
    set_pos(700, 450);
    set_pos(1000, 899);
    set_pos(1439, 899);
  endtask

  task automatic new_frame();
    set_pos(0, 0);
  endtask

  task automatic done_pulse();
    upd_done = 1'b1;
    step();
    upd_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    curr_x    = 11'd0;
    curr_y    = 11'd0;
    pause     = 1'b0;
    speed_sel = 2'd3;
    upd_done  = 1'b0;
    step();
    step();
    chk("rst_upd_req", 32'(upd_req), 32'd0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("rst_tick", 32'(tick_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    step();

    // Divide-by-2: request after frames 2 and 4, single event per held frame end
    reach_end();
    chk("f1_no_req", 32'(upd_req), 32'd0);
    repeat (4) step();
    chk("f1_hold_no_req", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("f2_req", 32'(upd_req), 32'd1);
    chk("f2_mem_sel", 32'(mem_sel), 32'd1);
    repeat (9) step();
    done_pulse();
    chk("done_upd_req", 32'(upd_req), 32'd0);
    chk("done_mem_sel", 32'(mem_sel), 32'd0);
    chk("done_tick", 32'(tick_count), 32'd1);
    chk("done_overrun", 32'(overrun), 32'd0);
    repeat (3) step();
    chk("f2_hold_no_retrig", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("f3_no_req", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("f4_req", 32'(upd_req), 32'd1);

    // Done coincident with frame start
    upd_done = 1'b1;
    set_pos(0, 0);
    upd_done = 1'b0;
    chk("coinc_tick", 32'(tick_count), 32'd2);
    chk("coinc_overrun", 32'(overrun), 32'd0);
    chk("coinc_upd_req", 32'(upd_req), 32'd0);
    chk("coinc_mem_sel", 32'(mem_sel), 32'd0);

    // Overrun: frame start while still granted
    reach_end();
    chk("f5_no_req", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("f6_req", 32'(upd_req), 32'd1);
    new_frame();
    chk("late_mem_sel", 32'(mem_sel), 32'd0);
    chk("late_upd_req", 32'(upd_req), 32'd1);
    chk("late_overrun", 32'(overrun), 32'd1);
    reach_end();
    chk("late_fe_req", 32'(upd_req), 32'd1);
    chk("late_fe_mem_sel", 32'(mem_sel), 32'd0);
    done_pulse();
    chk("late_done_req", 32'(upd_req), 32'd0);
    chk("late_done_tick", 32'(tick_count), 32'd3);
    chk("late_done_overrun", 32'(overrun), 32'd1);
    new_frame();
    reach_end();
    chk("f8_no_req", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("f9_req", 32'(upd_req), 32'd1);
    done_pulse();
    chk("f9_tick", 32'(tick_count), 32'd4);
    new_frame();

    // Pause with divider parked at 1
    reach_end();
    chk("f10_no_req", 32'(upd_req), 32'd0);
    new_frame();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      reach_end();
      chk($sformatf("pause_%0d", i), 32'(upd_req), 32'd0);
      new_frame();
    end
    pause = 1'b0;
    reach_end();
    chk("unpause_req", 32'(upd_req), 32'd1);
    done_pulse();
    chk("unpause_tick", 32'(tick_count), 32'd5);
    new_frame();

    // Divisor change mid-count applies after the next update
    rst       = 1'b0;
    speed_sel = 2'd0;
    step();
    chk("rst2_tick", 32'(tick_count), 32'd0);
    chk("rst2_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    step();
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) speed_sel = 2'd3;
      reach_end();
      chk($sformatf("div8_f%0d", i), 32'(upd_req), 32'd0);
      new_frame();
    end
    reach_end();
    chk("div8_f8_req", 32'(upd_req), 32'd1);
    new_frame();
    chk("div8_overrun", 32'(overrun), 32'd1);
    done_pulse();
    chk("div8_tick", 32'(tick_count), 32'd1);
    reach_end();
    chk("div2_f9_no_req", 32'(upd_req), 32'd0);
    new_frame();
    reach_end();
    chk("div2_f10_req", 32'(upd_req), 32'd1);
    step();
    step();

    // Asynchronous reset while granted
    #2;
    rst = 1'b0;
    #1;
    chk("arst_upd_req", 32'(upd_req), 32'd0);
    chk("arst_mem_sel", 32'(mem_sel), 32'd0);
    chk("arst_tick", 32'(tick_count), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences game-state updates against the VGA raster so that the shared snake/food position memory is only written during vertical blanking.
- Watches the pixel coordinates produced by the VGA timing block and detects end-of-frame and start-of-frame.
- Every N frames it grants the memory to the game logic with a req/done handshake, then returns the memory to the renderer.
- Sits between the VGA timing block, the renderer and the game-logic FSM.

Parameters:
- H_LAST, 1439: last visible curr_x value.
- V_LAST, 899: last visible curr_y value.
- DIV0, 8: frames per update when speed_sel=0.
- DIV1, 6: frames per update when speed_sel=1.
- DIV2, 4: frames per update when speed_sel=2.
- DIV3, 2: frames per update when speed_sel=3. Every DIVn must be ≥1 and ≤255.

Ports:
- clk  in  1  pixel clock; the same clock that drives the VGA timing block.
- rst  in  1  asynchronous, active-low reset.
- curr_x  in  11  current visible pixel x from the VGA timing block; holds its last value during blanking.
- curr_y  in  11  current visible pixel y; holds V_LAST throughout vertical blanking.
- pause  in  1  level; while high, no new updates are issued.
- speed_sel  in  2  selects the divisor DIV0..DIV3.
- upd_done  in  1  one-cycle pulse from game logic: update complete.
- upd_req  out  1  level; game logic may perform one update.
- mem_sel  out  1  memory owner: 0 = renderer, 1 = game logic.
- tick_count  out  16  number of completed updates; wraps 65535 to 0.
- overrun  out  1  sticky flag; an update was still pending at frame start.

Behaviour:
- Reset values: upd_req=0, mem_sel=0, tick_count=0, overrun=0, frame divider=0, state=RUN, curr_y_d=0, pos_last_d=0.
- Event detection:
  - pos_last = (curr_x==H_LAST && curr_y==V_LAST).
  - frame_end = pos_last & ~pos_last_d, where pos_last_d is pos_last registered.
  - frame_start = (curr_y_d==V_LAST) && (curr_y!=V_LAST), where curr_y_d is curr_y registered.
  - Both are single-cycle combinational strobes.
- Divisor:
  - The active divisor is latched from speed_sel at reset release (reset selects DIV0) and again on each issued update.
  - A speed_sel change therefore takes effect after the next update.
- Frame divider:
  - 8-bit counter, incremented on each frame_end while state=RUN and pause=0.
  - Held unchanged while pause=1.
- State RUN:
  - mem_sel=0, upd_req=0.
  - On frame_end with pause=0 and divider==divisor−1: next edge sets divider=0, upd_req=1, mem_sel=1, latches the divisor, and moves to GRANT.
  - Otherwise frame_end with pause=0 increments the divider.
  - Latency: upd_req rises one clock after the cycle in which frame_end is true.
  - upd_done received in RUN is ignored.
- State GRANT:
  - upd_req=1, mem_sel=1.
  - upd_done → next edge: upd_req=0, mem_sel=0, tick_count+1, go to RUN.
  - frame_start without upd_done → next edge: overrun=1, mem_sel=0 (renderer reclaims memory), upd_req stays 1, go to LATE.
  - upd_done and frame_start in the same cycle: done wins; no overrun.
- State LATE:
  - upd_req=1, mem_sel=0.
  - upd_done → upd_req=0, tick_count+1, go to RUN.
  - frame_end events are not counted while in LATE.
- pause asserted in GRANT or LATE does not abort the outstanding request.
- overrun is cleared only by reset.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously), including dropping upd_req.
- frame_end is edge-based: holding curr_x/curr_y at (H_LAST, V_LAST) for many cycles produces exactly one event.

Test Plan:
- Reset, speed_sel=3. Drive 4 frames by stepping curr_y 0→899, with curr_x hitting 1439 on line 899, then curr_y back to 0. Required: upd_req rises 1 clk after the 2nd and 4th frame_end, mem_sel=1 with it, and frame_end is seen once per frame despite the multi-cycle hold.
- In GRANT, pulse upd_done 10 clks after upd_req rises. Required: next edge upd_req=0, mem_sel=0, tick_count 0→1, overrun=0.
- In GRANT, drive curr_y 899→0 with no upd_done. Required: next edge mem_sel=0, upd_req=1, overrun=1. A later upd_done gives tick_count+1 and upd_req=0, and overrun stays 1.
- upd_done coincident with frame_start. Required: overrun stays 0 and tick_count increments.
- pause=1 across 10 frames with speed_sel=3. Required: no upd_req and divider unchanged. After pause=0, upd_req follows the 1st frame_end if the divider was at 1, otherwise the 2nd.
- Change speed_sel 0→3 mid-count, then assert rst low during GRANT. Required: DIV0=8 still governs the current interval and DIV3 applies after the update. On rst low, upd_req/mem_sel/tick_count/overrun go to 0 immediately.
